// File: rtl/uart_rx_pkg.sv
// Shared encodings for the UART receive-side FIFO: capture states, status bits, entry layout.
package uart_rx_pkg;

   localparam int unsigned ENTRY_W = 10;

   // Capture FSM encoding
   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_PUSH  = 2'b01;
   localparam logic [1:0] ST_CLEAR = 2'b10;

   // rx_status bit indices
   localparam int unsigned STAT_OVF  = 3;
   localparam int unsigned STAT_FERR = 2;
   localparam int unsigned STAT_PERR = 1;
   localparam int unsigned STAT_RDY  = 0;

   // Entry field positions
   localparam int unsigned E_FERR     = 9;
   localparam int unsigned E_PERR     = 8;
   localparam int unsigned E_DATA_MSB = 7;

   // Build one FIFO entry from the engine's byte and error flags
   function automatic logic [ENTRY_W-1:0] pack_entry(input logic       ferr,
                                                     input logic       perr,
                                                     input logic [7:0] data);
      logic [ENTRY_W-1:0] e;
      e = '0;
      e[E_FERR]         = ferr;
      e[E_PERR]         = perr;
      e[E_DATA_MSB:0]   = data;
      return e;
   endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Register-array storage: one synchronous write port, one asynchronous read port.
module fifo_mem_2p #(
   parameter int unsigned AW = 4,
   parameter int unsigned EW = 10
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [EW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [EW-1:0] rdata
);

   localparam int unsigned DEPTH = 2 ** AW;

   logic [EW-1:0] mem [DEPTH];

   // Write port; contents are intentionally not reset
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO: captures each engine frame once, re-arms the engine, FWFT CPU read port.
module uart_rx_fifo
   import uart_rx_pkg::*;
#(
   parameter int unsigned AW = 4,
   parameter int unsigned EW = 10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [7:0]    rx_data,
   input  logic [3:0]    rx_status,
   output logic          rx_clr,
   input  logic          rd,
   output logic [EW-1:0] rd_data,
   output logic          empty,
   output logic          full,
   output logic [AW:0]   count,
   output logic          ovr,
   input  logic          ovr_clr
);

   localparam int unsigned DEPTH = 2 ** AW;
   localparam int unsigned CW    = AW + 1;

   logic [1:0]    state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          empty_q, empty_d;
   logic          full_q, full_d;
   logic          ovr_q, ovr_d;
   logic          rx_clr_q, rx_clr_d;

   logic          we;
   logic          pop;
   logic          space;
   logic [EW-1:0] wdata;
   logic [EW-1:0] mem_rdata;

   fifo_mem_2p #(.AW(AW), .EW(EW)) u_mem (
      .clk   (clk),
      .we    (we),
      .waddr (wr_ptr_q),
      .wdata (wdata),
      .raddr (rd_ptr_q),
      .rdata (mem_rdata)
   );

   // Capture FSM, pointer/count bookkeeping and overrun flag
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ovr_d    = ovr_q;
      we       = 1'b0;
      wdata    = EW'(pack_entry(rx_status[STAT_FERR], rx_status[STAT_PERR], rx_data));
      pop      = rd && !empty_q;
      // A pop in the PUSH cycle frees the slot the new byte needs
      space    = (count_q < CW'(DEPTH)) || pop;

      if (ovr_clr) ovr_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (rx_status[STAT_RDY]) state_d = ST_PUSH;
         end
         ST_PUSH: begin
            state_d = ST_CLEAR;
            if (space) we = 1'b1;
            else       ovr_d = 1'b1;
            if (rx_status[STAT_OVF]) ovr_d = 1'b1;
         end
         ST_CLEAR: begin
            if (!rx_status[STAT_RDY]) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (we)  wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

      count_d  = count_q + CW'(we) - CW'(pop);
      empty_d  = (count_d == '0);
      full_d   = (count_d == CW'(DEPTH));
      rx_clr_d = (state_d == ST_CLEAR);
   end

   // State and status registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         ovr_q    <= 1'b0;
         rx_clr_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
         ovr_q    <= ovr_d;
         rx_clr_q <= rx_clr_d;
      end
   end

   assign rd_data = empty_q ? '0 : mem_rdata;
   assign empty   = empty_q;
   assign full    = full_q;
   assign count   = count_q;
   assign ovr     = ovr_q;
   assign rx_clr  = rx_clr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized self-checking bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

   localparam int unsigned DEPTH = 16;

   logic       clk;
   logic       reset;
   logic [7:0] rx_data;
   logic [3:0] rx_status;
   logic       rx_clr;
   logic       rd;
   logic [9:0] rd_data;
   logic       empty;
   logic       full;
   logic [4:0] count;
   logic       ovr;
   logic       ovr_clr;

   int n_checks;
   int n_errors;

   // Reference model: buffered entries and sticky overrun
   logic [9:0] model_q[$];
   logic       model_ovr;

   uart_rx_fifo dut (
      .clk       (clk),
      .reset     (reset),
      .rx_data   (rx_data),
      .rx_status (rx_status),
      .rx_clr    (rx_clr),
      .rd        (rd),
      .rd_data   (rd_data),
      .empty     (empty),
      .full      (full),
      .count     (count),
      .ovr       (ovr),
      .ovr_clr   (ovr_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] head_exp();
      return (model_q.size() == 0) ? 10'h000 : model_q[0];
   endfunction

   task automatic chk_status(input string tag);
      chk({tag, ".count"}, 32'(count), 32'(model_q.size()));
      chk({tag, ".empty"}, 32'(empty), 32'(model_q.size() == 0));
      chk({tag, ".full"},  32'(full),  32'(model_q.size() == DEPTH));
      chk({tag, ".ovr"},   32'(ovr),   32'(model_ovr));
      chk({tag, ".rd_data"}, 32'(rd_data), 32'(head_exp()));
   endtask

   // One engine frame: rxrdy high until re-armed, optional pop during the PUSH cycle
   task automatic send_frame(input logic [7:0] d, input logic ferr, input logic perr,
                             input logic ovf, input logic pop_on_push, input int hold);
      logic popped;
      rx_data   = d;
      rx_status = {ovf, ferr, perr, 1'b1};
      @(posedge clk);
      @(negedge clk);
      if (pop_on_push) begin
         chk("push_rd.rd_data", 32'(rd_data), 32'(head_exp()));
         rd = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      rd = 1'b0;
      popped = pop_on_push && (model_q.size() != 0);
      if (popped) void'(model_q.pop_front());
      if (model_q.size() < DEPTH) model_q.push_back({ferr, perr, d});
      else                        model_ovr = 1'b1;
      if (ovf) model_ovr = 1'b1;
      chk("frame.rx_clr", 32'(rx_clr), 32'd1);
      chk_status("frame");
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold.rx_clr", 32'(rx_clr), 32'd1);
      end
      rx_status = 4'b0000;
      @(negedge clk);
      chk("idle.rx_clr", 32'(rx_clr), 32'd0);
   endtask

   // One CPU read: check the head, pulse rd for a cycle
   task automatic do_read();
      chk("read.rd_data", 32'(rd_data), 32'(head_exp()));
      rd = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rd = 1'b0;
      if (model_q.size() != 0) void'(model_q.pop_front());
      chk_status("read");
   endtask

   task automatic clear_ovr();
      ovr_clr = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ovr_clr   = 1'b0;
      model_ovr = 1'b0;
      chk("ovr_clr.ovr", 32'(ovr), 32'd0);
   endtask

   initial begin
      logic [7:0] b;
      int         op;
      n_checks  = 0;
      n_errors  = 0;
      model_ovr = 1'b0;
      reset     = 1'b1;
      rx_data   = 8'h00;
      rx_status = 4'b0000;
      rd        = 1'b0;
      ovr_clr   = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset.rx_clr", 32'(rx_clr), 32'd0);
      chk_status("reset");
      reset = 1'b0;
      @(negedge clk);

      // Single byte
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1);
      chk("single.rd_data", 32'(rd_data), 32'h0A5);
      do_read();

      // Error flags and engine overrun
      send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      chk("errflags.rd_data", 32'(rd_data), 32'h33C);
      chk("errflags.ovr", 32'(ovr), 32'd0);
      send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 2);
      chk("engine_ovf.ovr", 32'(ovr), 32'd1);
      do_read();
      do_read();
      chk("ovr_sticky.ovr", 32'(ovr), 32'd1);
      clear_ovr();

      // Overflow: 16 bytes fill, the 17th is dropped
      for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0, 1'b0, 0);
      send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1);
      chk("overflow.count", 32'(count), 32'd16);
      chk("overflow.ovr", 32'(ovr), 32'd1);
      for (int i = 0; i < 16; i++) begin
         chk("overflow.order", 32'(rd_data), 32'(i));
         do_read();
      end
      chk("overflow.empty", 32'(empty), 32'd1);
      clear_ovr();

      // Wrap-around: pop each byte before the next
      for (int i = 0; i < 40; i++) begin
         send_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0, int'($urandom_range(0, 2)));
         chk("wrap.count_le1", 32'(count <= 5'd1), 32'd1);
         do_read();
      end

      // Full with a pop on the PUSH cycle, then rd while empty
      for (int i = 0; i < 16; i++) send_frame(8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 0);
      send_frame(8'hC3, 1'b0, 1'b1, 1'b0, 1'b1, 0);
      chk("full_pop.count", 32'(count), 32'd16);
      chk("full_pop.full", 32'(full), 32'd1);
      chk("full_pop.ovr", 32'(ovr), 32'd0);
      for (int i = 0; i < 16; i++) do_read();
      chk("full_pop.last", 32'(rd_data), 32'h000);
      do_read();
      chk("rd_empty.count", 32'(count), 32'd0);
      send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      chk("empty_pop.count", 32'(count), 32'd1);
      do_read();

      // Random mix of frames, reads and overrun clears
      for (int it = 0; it < 300; it++) begin
         op = int'($urandom_range(0, 9));
         if (op < 5) begin
            b = 8'($urandom);
            send_frame(b, 1'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0),
                       1'($urandom), int'($urandom_range(0, 2)));
         end else if (op < 9) begin
            do_read();
         end else begin
            clear_ovr();
         end
      end

      // Reset asserted in CLEAR with rxrdy held high
      rx_data   = 8'h5A;
      rx_status = 4'b0001;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("rst_mid.rx_clr_pre", 32'(rx_clr), 32'd1);
      reset = 1'b1;
      #1;
      model_q.delete();
      model_ovr = 1'b0;
      chk("rst_mid.rx_clr", 32'(rx_clr), 32'd0);
      chk_status("rst_mid");
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      model_q.push_back(10'h05A);
      chk_status("recapture");
      chk("recapture.rx_clr", 32'(rx_clr), 32'd1);
      rx_status = 4'b0000;
      @(negedge clk);
      do_read();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
